rnd_harvester: RTL and testbench

Parametrised successor to the free-running random bank readout in the SNPU top. It takes the raw bits of N_CH oscillator-based generator channels, each W bits wide. It synchronises the selected or folded source and optionally whitens it with a von Neumann extractor. Finished words are buffered in a DEPTH-entry FIFO with a valid/ready output, and the block gates the oscillator bank on only while harvesting.

---
 rtl/snpu_rnd_pkg.sv | 33 +++
 rtl/rnd_fifo.sv | 96 +++++++++
 rtl/rnd_harvester.sv | 229 ++++++++++++++++++++++
 tb/tb_rnd_harvester.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snpu_rnd_pkg.sv
// Shared types and width helpers for the random-bit harvester.
package snpu_rnd_pkg;

    localparam int MODE_W = 2;

    // Source / extraction mode as latched on start.
    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_XOR  = 2'd1,
        MODE_VN   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Harvest sequencing.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARM    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_PUSH    = 2'd3
    } state_e;

    // Bits needed for a counter that must hold values 0..max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        if (max_val < 2) begin
            w = 1;
        end else begin
            w = $clog2(max_val + 1);
        end
        return w;
    endfunction

endpackage

// File: rtl/rnd_fifo.sv
// First-word-fall-through FIFO with a registered head word.
// The head register keeps its last value when the FIFO drains.
module rnd_fifo
    import snpu_rnd_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [W-1:0]     head_r;
    logic [W-1:0]     head_next_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Full is judged on the registered state, so a same-cycle pop never frees room.
    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Next head word: following entry on pop, incoming word when it lands at the head.
    always_comb begin
        head_next_s = head_r;
        if (do_pop_s && (count_r > CNT_W'(1))) begin
            head_next_s = mem_r[rd_ptr_r + PTR_W'(1)];
        end else if (do_push_s && ((count_r == CNT_W'(0)) || (do_pop_s && (count_r == CNT_W'(1))))) begin
            head_next_s = wr_data;
        end else begin
            head_next_s = head_r;
        end
    end

    // Storage array write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            head_r  <= head_next_s;
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            empty_r <= (count_next_s == CNT_W'(0));
        end
    end

    assign rd_data = head_r;
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/rnd_harvester.sv
// Random-bit harvester: source select/fold, 2-flop synchroniser, harvest FSM,
// von Neumann extractor and output FIFO. osc_run gates the oscillator bank.
module rnd_harvester
    import snpu_rnd_pkg::*;
#(
    parameter int N_CH       = 36,
    parameter int W          = 16,
    parameter int DEPTH      = 8,
    parameter int WARMUP     = 4,
    parameter int SAMPLE_DIV = 1,
    parameter int CH_W       = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*W-1:0]        rnd_in,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic [1:0]               mode,
    input  logic                     cont,
    input  logic                     start,
    output logic                     osc_run,
    output logic                     busy,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int WARM_W = cnt_width(WARMUP - 1);
    localparam int DIV_W  = cnt_width(SAMPLE_DIV - 1);
    localparam int BIT_W  = cnt_width(W);

    state_e             state_r;
    state_e             state_next_s;
    mode_e              mode_q_r;
    logic [CH_W-1:0]    ch_sel_q_r;
    logic [W-1:0]       fold_s;
    logic [W-1:0]       pick_s;
    logic [W-1:0]       src_s;
    logic [W-1:0]       sync1_r;
    logic [W-1:0]       sync2_r;
    logic [WARM_W-1:0]  warm_cnt_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic               vn_phase_r;
    logic               vn_a_r;
    logic [W-1:0]       word_r;
    logic               overflow_r;
    logic               osc_run_r;
    logic               busy_r;
    logic               tick_s;
    logic               warm_last_s;
    logic               raw_capture_s;
    logic               vn_accept_s;
    logic               vn_done_s;
    logic               push_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // XOR fold of every channel.
    always_comb begin
        fold_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            fold_s = fold_s ^ rnd_in[i*W +: W];
        end
    end

    // Latched-channel pick; the latched index is always below N_CH.
    always_comb begin
        pick_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel_q_r == CH_W'(i)) begin
                pick_s = rnd_in[i*W +: W];
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Mode select ahead of the synchroniser so only W bits cross domains.
    always_comb begin
        src_s = pick_s;
        if (mode_q_r == MODE_XOR) begin
            src_s = fold_s;
        end else begin
            src_s = pick_s;
        end
    end

    assign tick_s        = (div_cnt_r == DIV_W'(0));
    assign warm_last_s   = (warm_cnt_r == WARM_W'(WARMUP - 1));
    assign raw_capture_s = tick_s & (mode_q_r != MODE_VN);
    assign vn_accept_s   = tick_s & (mode_q_r == MODE_VN) & vn_phase_r & (vn_a_r != sync2_r[0]);
    assign vn_done_s     = vn_accept_s & (bit_cnt_r == BIT_W'(W - 1));
    assign push_s        = (state_r == ST_PUSH);

    // Next-state logic for the harvest sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_WARM;
                else       state_next_s = ST_IDLE;
            end
            ST_WARM: begin
                if (warm_last_s) state_next_s = ST_COLLECT;
                else             state_next_s = ST_WARM;
            end
            ST_COLLECT: begin
                if (raw_capture_s || vn_done_s) state_next_s = ST_PUSH;
                else                            state_next_s = ST_COLLECT;
            end
            ST_PUSH: begin
                if (cont) state_next_s = ST_COLLECT;
                else      state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus registered oscillator-enable and busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            osc_run_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            osc_run_r <= (state_next_s != ST_IDLE);
            busy_r    <= (state_next_s != ST_IDLE);
        end
    end

    // Two-flop synchroniser for the asynchronous generator bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= src_s;
            sync2_r <= sync1_r;
        end
    end

    // Harvest datapath: config latch, warm-up, sample divider, VN pairing, overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q_r   <= MODE_RAW;
            ch_sel_q_r <= '0;
            warm_cnt_r <= '0;
            div_cnt_r  <= '0;
            bit_cnt_r  <= '0;
            vn_phase_r <= 1'b0;
            vn_a_r     <= 1'b0;
            word_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_q_r   <= mode_e'(mode);
                        ch_sel_q_r <= ({1'b0, ch_sel} < (CH_W+1)'(N_CH)) ? ch_sel : '0;
                        overflow_r <= 1'b0;
                        warm_cnt_r <= '0;
                    end
                end
                ST_WARM: begin
                    warm_cnt_r <= warm_cnt_r + WARM_W'(1);
                    div_cnt_r  <= '0;
                    bit_cnt_r  <= '0;
                    vn_phase_r <= 1'b0;
                end
                ST_COLLECT: begin
                    if (div_cnt_r == DIV_W'(SAMPLE_DIV - 1)) begin
                        div_cnt_r <= '0;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                    if (raw_capture_s) begin
                        word_r <= sync2_r;
                    end else if (tick_s && (mode_q_r == MODE_VN)) begin
                        if (!vn_phase_r) begin
                            vn_a_r     <= sync2_r[0];
                            vn_phase_r <= 1'b1;
                        end else begin
                            vn_phase_r <= 1'b0;
                            if (vn_accept_s) begin
                                word_r    <= {word_r[W-2:0], vn_a_r};
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                    end
                end
                ST_PUSH: begin
                    if (fifo_full_s) begin
                        overflow_r <= 1'b1;
                    end
                    div_cnt_r  <= '0;
                    bit_cnt_r  <= '0;
                    vn_phase_r <= 1'b0;
                end
                default: begin
                    div_cnt_r <= '0;
                end
            endcase
        end
    end

    rnd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (word_r),
        .pop     (out_ready),
        .rd_data (out_data),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    assign out_valid = ~fifo_empty_s;
    assign osc_run   = osc_run_r;
    assign busy      = busy_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_rnd_harvester.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rnd_harvester;

    localparam int N_CH       = 36;
    localparam int W          = 16;
    localparam int DEPTH      = 8;
    localparam int WARMUP     = 4;
    localparam int SAMPLE_DIV = 1;
    localparam int CH_W       = $clog2(N_CH);
    localparam int CNT_W      = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH*W-1:0]   rnd_in;
    logic [CH_W-1:0]     ch_sel;
    logic [1:0]          mode;
    logic                cont;
    logic                start;
    logic                osc_run;
    logic                busy;
    logic [W-1:0]        out_data;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    fifo_count;
    logic                overflow;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rnd_harvester #(
        .N_CH(N_CH), .W(W), .DEPTH(DEPTH), .WARMUP(WARMUP), .SAMPLE_DIV(SAMPLE_DIV), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .rnd_in(rnd_in), .ch_sel(ch_sel), .mode(mode), .cont(cont),
        .start(start), .osc_run(osc_run), .busy(busy), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (harvest as phases + word queue) -------------
    int               m_ph = 0;     // 0 idle, 1 warm, 2 collect, 3 push
    int               m_wcnt, m_dcnt, m_bits;
    bit               m_half;
    logic             m_a;
    logic [W-1:0]     m_word;
    logic [1:0]       m_mode = 2'd0;
    int               m_ch = 0;
    logic [W-1:0]     m_q[$];
    logic             m_ovf = 1'b0;
    logic [W-1:0]     m_last = '0;
    logic [N_CH*W-1:0] r_m1 = '0;
    logic [N_CH*W-1:0] r_m2 = '0;

    function automatic logic [W-1:0] src_of(input logic [N_CH*W-1:0] r, input logic [1:0] md, input int ch);
        logic [W-1:0] acc;
        acc = '0;
        if (md == 2'd1) begin
            for (int i = 0; i < N_CH; i++) acc = acc ^ r[i*W +: W];
        end else begin
            acc = r[ch*W +: W];
        end
        return acc;
    endfunction

    task automatic model_step();
        logic [W-1:0] s;
        bit full;
        bit tick;
        s = src_of(r_m2, m_mode, m_ch);   // synchronised value is two samples old
        if (rst) begin
            m_ph = 0;
            m_q.delete();
            m_ovf = 1'b0;
            m_last = '0;
        end else begin
            full = (m_q.size() == DEPTH);
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            case (m_ph)
                0: if (start) begin
                    m_mode = mode;
                    m_ch   = (int'(ch_sel) < N_CH) ? int'(ch_sel) : 0;
                    m_ovf  = 1'b0;
                    m_wcnt = 0;
                    m_ph   = 1;
                end
                1: begin
                    m_wcnt++;
                    if (m_wcnt == WARMUP) begin
                        m_ph = 2; m_dcnt = 0; m_bits = 0; m_half = 0;
                    end
                end
                2: begin
                    tick = (m_dcnt == 0);
                    m_dcnt = (m_dcnt + 1) % SAMPLE_DIV;
                    if (tick) begin
                        if (m_mode != 2'd2) begin
                            m_word = s;
                            m_ph = 3;
                        end else if (!m_half) begin
                            m_a = s[0];
                            m_half = 1;
                        end else begin
                            m_half = 0;
                            if (m_a != s[0]) begin
                                m_word = {m_word[W-2:0], m_a};
                                m_bits++;
                                if (m_bits == W) m_ph = 3;
                            end
                        end
                    end
                end
                default: begin
                    if (full) m_ovf = 1'b1;
                    else      m_q.push_back(m_word);
                    if (cont) begin
                        m_ph = 2; m_dcnt = 0; m_bits = 0; m_half = 0;
                    end else begin
                        m_ph = 0;
                    end
                end
            endcase
        end
        if (m_q.size() > 0) m_last = m_q[0];
        r_m2 = r_m1;
        r_m1 = rnd_in;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("osc_run",    32'(osc_run),    32'(m_ph != 0));
                check("busy",       32'(busy),       32'(m_ph != 0));
                check("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
                check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
                check("overflow",   32'(overflow),   32'(m_ovf));
                check("out_data",   32'(out_data),   32'(m_last));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic rand_rnd();
        for (int i = 0; i < (N_CH*W)/32; i++) rnd_in[i*32 +: 32] = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; cont = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    logic [7:0] seq_v;
    int guard;

    initial begin
        rst = 1'b1; rnd_in = '0; ch_sel = '0; mode = 2'd0; cont = 1'b0; start = 1'b0; out_ready = 1'b0;
        step(); step();
        chk_en = 1'b1;
        check("rst_osc_run", 32'(osc_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst = 1'b0;

        // 1: RAW latency on channel 3
        do_reset();
        rnd_in = '0; rnd_in[3*W +: W] = 16'hA5C3;
        mode = 2'd0; ch_sel = CH_W'(3); start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            start = 1'b0;
            check("t1_osc_run", 32'(osc_run), 32'(k <= 6));
            if (k == 6) check("t1_valid_early", 32'(out_valid), 32'd0);
            if (k == 7) begin
                check("t1_valid", 32'(out_valid), 32'd1);
                check("t1_data", 32'(out_data), 32'hA5C3);
                check("t1_busy", 32'(busy), 32'd0);
                check("t1_count", 32'(fifo_count), 32'd1);
            end
        end

        // 2: XOR fold of two channels
        do_reset();
        rnd_in = '0; rnd_in[0 +: W] = 16'h1234; rnd_in[5*W +: W] = 16'h00FF;
        mode = 2'd1; ch_sel = CH_W'(9); start = 1'b1;
        step(); start = 1'b0;
        repeat (10) step();
        check("t2_data", 32'(out_data), 32'h12CB);
        check("t2_count", 32'(fifo_count), 32'd1);

        // 3: von Neumann on bit 0 of channel 2, pattern aligned to COLLECT entry
        do_reset();
        seq_v = 8'b0001_1110;
        mode = 2'd2; ch_sel = CH_W'(2);
        for (int n = 0; n < 80; n++) begin
            rand_rnd();
            rnd_in[2*W] = seq_v[(n + 5) % 8];
            start = (n == 0);
            step();
        end
        check("t3_data", 32'(out_data), 32'h5555);
        check("t3_count", 32'(fifo_count), 32'd1);

        // 4: overflow with incrementing data, then ordered drain
        do_reset();
        rnd_in = '0; mode = 2'd0; ch_sel = '0; cont = 1'b1;
        for (int n = 0; n < 30; n++) begin
            rnd_in[0 +: W] = W'(n);
            start = (n == 0);
            if (n == 27) cont = 1'b0;
            step();
        end
        check("t4_count_full", 32'(fifo_count), 32'd8);
        check("t4_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_data", 32'(out_data), 32'(3 + 2*i));
            step();
        end
        check("t4_drained", 32'(out_valid), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b0;

        // 5: reset mid-COLLECT with three words buffered
        rnd_in = '0; rnd_in[0 +: W] = 16'h0F0F; mode = 2'd0; ch_sel = '0; cont = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        repeat (10) step();
        check("t5_count_pre", 32'(fifo_count), 32'd3);
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        rst = 1'b1;
        step();
        check("t5_osc_run", 32'(osc_run), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        rst = 1'b0; cont = 1'b0;

        // 6: start pulses and config changes after start are ignored
        do_reset();
        rnd_in = '0; rnd_in[1*W +: W] = 16'hBEEF; rnd_in[7*W +: W] = 16'hDEAD;
        mode = 2'd0; ch_sel = CH_W'(1); cont = 1'b1; start = 1'b1;
        step();
        for (int n = 1; n <= 12; n++) begin
            ch_sel = CH_W'(7); mode = 2'd1; start = n[0];
            step();
        end
        start = 1'b0; cont = 1'b0;
        repeat (4) step();
        check("t6_count", 32'(fifo_count), 32'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t6_data", 32'(out_data), 32'hBEEF);
            step();
        end
        check("t6_drained", 32'(out_valid), 32'd0);

        // Randomized traffic, checked by the model every cycle
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            rand_rnd();
            mode      = 2'($urandom);
            ch_sel    = CH_W'($urandom);
            start     = ($urandom_range(0, 15) == 0);
            cont      = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; start = 1'b0; cont = 1'b0;
        guard = 0;
        while (m_ph != 0 && guard < 3000) begin
            rand_rnd();
            step();
            guard++;
        end
        if (guard >= 3000) begin
            total++; bad++;
            $display("FAIL rand_wind_down: harvest still active after %0d cycles, required idle", guard);
        end
        out_ready = 1'b1;
        repeat (12) step();
        check("rand_drained", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
